// File: rtl/auto_player_if.sv
// Auto-player control/status bundle shared between the mode top-level
// (master) and the auto_player sequencer (slave).
interface auto_player_if #(
    parameter int SONG_W = 3,
    parameter int CNT_W  = 8
);
    logic              en;
    logic [SONG_W-1:0] song_sel;
    logic [1:0]        mode;
    logic              pause;
    logic              next_btn;
    logic              prev_btn;
    logic [CNT_W-1:0]  rom_track;
    logic              note_over;
    logic [SONG_W-1:0] song_idx;
    logic [CNT_W-1:0]  note_idx;
    logic              sound_en;
    logic              playing;
    logic              song_done;

    modport master (
        output en, song_sel, mode, pause, next_btn, prev_btn, rom_track, note_over,
        input  song_idx, note_idx, sound_en, playing, song_done
    );

    modport slave (
        input  en, song_sel, mode, pause, next_btn, prev_btn, rom_track, note_over,
        output song_idx, note_idx, sound_en, playing, song_done
    );
endinterface

// File: rtl/auto_player.sv
// Auto-play sequencer: walks note indices of the current song through the
// external Song ROM, inserts a silent gap between notes, and selects the
// next song according to the play mode (sequential / repeat-one /
// play-once / shuffle). Supports pause and next/prev skipping.
module auto_player #(
    parameter int SONG_W     = 3,
    parameter int NUM_SONGS  = 8,
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    auto_player_if.slave bus
);
    localparam int                GAP_W       = $clog2(GAP_CYCLES + 1);
    localparam logic [SONG_W-1:0] LAST_SONG   = SONG_W'(NUM_SONGS - 1);
    localparam logic [SONG_W-1:0] SONG_ONE    = SONG_W'(32'd1);
    localparam logic [CNT_W-1:0]  NOTE_ONE    = CNT_W'(32'd1);
    localparam logic [GAP_W-1:0]  GAP_ONE     = GAP_W'(32'd1);
    localparam logic [GAP_W-1:0]  GAP_LOAD    = GAP_W'(GAP_CYCLES - 1);
    localparam logic [31:0]       NUM_SONGS_U = 32'(NUM_SONGS);
    localparam logic [7:0]        LFSR_SEED   = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        GAP     = 3'd2,
        PAUSED  = 3'd3,
        STOPPED = 3'd4
    } state_t;

    state_t            state_r;
    logic [SONG_W-1:0] song_idx_r;
    logic [CNT_W-1:0]  note_idx_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [7:0]        lfsr_r;
    logic              sound_en_r;
    logic              playing_r;
    logic              song_done_r;

    logic              lfsr_fb_s;
    logic              skip_s;
    logic [SONG_W-1:0] song_inc_s;
    logic [SONG_W-1:0] song_dec_s;
    logic [SONG_W-1:0] song_shuf_s;
    logic [SONG_W-1:0] song_skip_s;
    logic [SONG_W-1:0] song_end_s;

    // Forward one song, wrapping at NUM_SONGS.
    function automatic logic [SONG_W-1:0] song_plus1(input logic [SONG_W-1:0] s);
        logic [SONG_W-1:0] r;
        if (s >= LAST_SONG) begin
            r = {SONG_W{1'b0}};
        end else begin
            r = s + SONG_ONE;
        end
        return r;
    endfunction

    // Back one song, wrapping to the last song.
    function automatic logic [SONG_W-1:0] song_minus1(input logic [SONG_W-1:0] s);
        logic [SONG_W-1:0] r;
        if (s == {SONG_W{1'b0}}) begin
            r = LAST_SONG;
        end else begin
            r = s - SONG_ONE;
        end
        return r;
    endfunction

    // Random song from the LFSR that is never the one just played.
    function automatic logic [SONG_W-1:0] shuffle_pick(input logic [7:0]        lfsr,
                                                       input logic [SONG_W-1:0] cur);
        logic [31:0]       m;
        logic [SONG_W-1:0] cand;
        logic [SONG_W-1:0] r;
        m    = {24'd0, lfsr} % NUM_SONGS_U;
        cand = SONG_W'(m);
        if (cand == cur) begin
            r = song_plus1(cand);
        end else begin
            r = cand;
        end
        return r;
    endfunction

    // Candidate song indices for skip buttons and natural end of song.
    always_comb begin
        lfsr_fb_s   = lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3];
        skip_s      = bus.next_btn | bus.prev_btn;
        song_inc_s  = song_plus1(song_idx_r);
        song_dec_s  = song_minus1(song_idx_r);
        song_shuf_s = shuffle_pick(lfsr_r, song_idx_r);
        if (bus.mode == 2'b11) begin
            song_skip_s = bus.next_btn ? song_shuf_s : song_dec_s;
        end else begin
            song_skip_s = bus.next_btn ? song_inc_s : song_dec_s;
        end
        case (bus.mode)
            2'b00:   song_end_s = song_inc_s;
            2'b11:   song_end_s = song_shuf_s;
            default: song_end_s = song_idx_r;
        endcase
    end

    // Playback FSM with registered outputs and free-running shuffle LFSR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            song_idx_r  <= {SONG_W{1'b0}};
            note_idx_r  <= {CNT_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            lfsr_r      <= LFSR_SEED;
            sound_en_r  <= 1'b0;
            playing_r   <= 1'b0;
            song_done_r <= 1'b0;
        end else begin
            lfsr_r      <= {lfsr_r[6:0], lfsr_fb_s};
            song_done_r <= 1'b0;
            if (!bus.en) begin
                state_r    <= IDLE;
                song_idx_r <= bus.song_sel;
                note_idx_r <= {CNT_W{1'b0}};
                gap_cnt_r  <= {GAP_W{1'b0}};
                sound_en_r <= 1'b0;
                playing_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r    <= PLAY;
                        sound_en_r <= 1'b1;
                        playing_r  <= 1'b1;
                    end
                    PLAY, GAP, PAUSED, STOPPED: begin
                        if (skip_s) begin
                            // Skips never count as a natural song end.
                            note_idx_r <= {CNT_W{1'b0}};
                            song_idx_r <= song_skip_s;
                            sound_en_r <= 1'b0;
                            if (bus.pause) begin
                                state_r   <= PAUSED;
                                gap_cnt_r <= {GAP_W{1'b0}};
                                playing_r <= 1'b0;
                            end else begin
                                state_r   <= GAP;
                                gap_cnt_r <= GAP_LOAD;
                                playing_r <= 1'b1;
                            end
                        end else if (bus.pause && (state_r == PLAY || state_r == GAP)) begin
                            state_r    <= PAUSED;
                            gap_cnt_r  <= {GAP_W{1'b0}};
                            sound_en_r <= 1'b0;
                            playing_r  <= 1'b0;
                        end else if (state_r == PLAY) begin
                            if (bus.note_over) begin
                                sound_en_r <= 1'b0;
                                if (note_idx_r < bus.rom_track) begin
                                    note_idx_r <= note_idx_r + NOTE_ONE;
                                    state_r    <= GAP;
                                    gap_cnt_r  <= GAP_LOAD;
                                    playing_r  <= 1'b1;
                                end else begin
                                    song_done_r <= 1'b1;
                                    note_idx_r  <= {CNT_W{1'b0}};
                                    song_idx_r  <= song_end_s;
                                    if (bus.mode == 2'b10) begin
                                        state_r   <= STOPPED;
                                        playing_r <= 1'b0;
                                    end else begin
                                        state_r   <= GAP;
                                        gap_cnt_r <= GAP_LOAD;
                                        playing_r <= 1'b1;
                                    end
                                end
                            end else begin
                                sound_en_r <= 1'b1;
                                playing_r  <= 1'b1;
                            end
                        end else if (state_r == GAP) begin
                            if (gap_cnt_r == {GAP_W{1'b0}}) begin
                                state_r    <= PLAY;
                                sound_en_r <= 1'b1;
                            end else begin
                                gap_cnt_r  <= gap_cnt_r - GAP_ONE;
                                sound_en_r <= 1'b0;
                            end
                            playing_r <= 1'b1;
                        end else if (state_r == PAUSED) begin
                            // Resuming replays the held note from its start after a gap.
                            if (!bus.pause) begin
                                state_r   <= GAP;
                                gap_cnt_r <= GAP_LOAD;
                                playing_r <= 1'b1;
                            end else begin
                                playing_r <= 1'b0;
                            end
                            sound_en_r <= 1'b0;
                        end else begin
                            sound_en_r <= 1'b0;
                            playing_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        sound_en_r <= 1'b0;
                        playing_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.song_idx  = song_idx_r;
    assign bus.note_idx  = note_idx_r;
    assign bus.sound_en  = sound_en_r;
    assign bus.playing   = playing_r;
    assign bus.song_done = song_done_r;
endmodule

// File: tb/tb_auto_player.sv
// Self-checking bench for auto_player: reset sequence, a table of
// cycle-level vectors (sequential, pause, play-once, skip, repeat-one) on an
// 8-song instance, and a 50-song shuffle run on a 5-song instance.
module tb_auto_player;
    logic clk;
    logic rst;
    int   total_cnt;
    int   pass_cnt;

    auto_player_if #(.SONG_W(3), .CNT_W(8)) ifa ();
    auto_player_if #(.SONG_W(3), .CNT_W(8)) ifb ();

    auto_player #(.SONG_W(3), .NUM_SONGS(8), .CNT_W(8), .GAP_CYCLES(4)) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ifa)
    );

    auto_player #(.SONG_W(3), .NUM_SONGS(5), .CNT_W(8), .GAP_CYCLES(4)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ifb)
    );

    typedef struct packed {
        logic       en;
        logic [2:0] sel;
        logic [1:0] mode;
        logic [7:0] rom;
        logic       pause;
        logic       nxt;
        logic       prv;
        logic       nover;
        logic [7:0] reps;
        logic [2:0] e_song;
        logic [7:0] e_note;
        logic       e_snd;
        logic       e_play;
        logic       e_done;
    } vec_t;

    vec_t        vecs[$];
    string       names[$];
    logic [13:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic void add(input string nm, input logic en, input logic [2:0] sel,
                                input logic [1:0] md, input logic [7:0] rom, input logic ps,
                                input logic nx, input logic pv, input logic no, input int reps,
                                input logic [2:0] es, input logic [7:0] enote, input logic esnd,
                                input logic eplay, input logic edone);
        vec_t v;
        v.en = en; v.sel = sel; v.mode = md; v.rom = rom; v.pause = ps;
        v.nxt = nx; v.prv = pv; v.nover = no; v.reps = 8'(reps);
        v.e_song = es; v.e_note = enote; v.e_snd = esnd; v.e_play = eplay; v.e_done = edone;
        vecs.push_back(v);
        names.push_back(nm);
    endfunction

    function automatic logic [13:0] outs_a();
        return {ifa.song_idx, ifa.note_idx, ifa.sound_en, ifa.playing, ifa.song_done};
    endfunction

    initial begin
        logic [2:0]  prev_song;
        logic [13:0] exp_o;
        int          w;
        total_cnt = 0;
        pass_cnt  = 0;
        rst = 1'b1;
        ifa.en = 1'b1; ifa.song_sel = 3'd0; ifa.mode = 2'b00; ifa.pause = 1'b0;
        ifa.next_btn = 1'b0; ifa.prev_btn = 1'b0; ifa.rom_track = 8'd2; ifa.note_over = 1'b0;
        ifb.en = 1'b0; ifb.song_sel = 3'd0; ifb.mode = 2'b11; ifb.pause = 1'b0;
        ifb.next_btn = 1'b0; ifb.prev_btn = 1'b0; ifb.rom_track = 8'd0; ifb.note_over = 1'b0;

        // Vector table: en sel mode rom pause next prev note_over reps | song note snd play done
        add("seed_sel7",        1'b0, 3'd7, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd7, 8'd0, 1'b0, 1'b0, 1'b0);
        add("idle_to_play",     1'b1, 3'd7, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd7, 8'd0, 1'b1, 1'b1, 1'b0);
        add("note1_gap",        1'b1, 3'd7, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3'd7, 8'd1, 1'b0, 1'b1, 1'b0);
        add("gap1_silent",      1'b1, 3'd7, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'd7, 8'd1, 1'b0, 1'b1, 1'b0);
        add("note1_play",       1'b1, 3'd7, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd7, 8'd1, 1'b1, 1'b1, 1'b0);
        add("note2_gap",        1'b1, 3'd7, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3'd7, 8'd2, 1'b0, 1'b1, 1'b0);
        add("gap2_silent",      1'b1, 3'd7, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'd7, 8'd2, 1'b0, 1'b1, 1'b0);
        add("note2_play",       1'b1, 3'd7, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd7, 8'd2, 1'b1, 1'b1, 1'b0);
        add("seq_end_wrap",     1'b1, 3'd7, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3'd0, 8'd0, 1'b0, 1'b1, 1'b1);
        add("seq_end_gap",      1'b1, 3'd7, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        add("song0_play",       1'b1, 3'd7, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd0, 8'd0, 1'b1, 1'b1, 1'b0);
        add("walk_n1",          1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3'd0, 8'd1, 1'b0, 1'b1, 1'b0);
        add("walk_g1",          1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'd0, 8'd1, 1'b0, 1'b1, 1'b0);
        add("walk_p1",          1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd0, 8'd1, 1'b1, 1'b1, 1'b0);
        add("walk_n2",          1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3'd0, 8'd2, 1'b0, 1'b1, 1'b0);
        add("walk_g2",          1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'd0, 8'd2, 1'b0, 1'b1, 1'b0);
        add("walk_p2",          1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd0, 8'd2, 1'b1, 1'b1, 1'b0);
        add("walk_n3",          1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3'd0, 8'd3, 1'b0, 1'b1, 1'b0);
        add("walk_g3",          1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'd0, 8'd3, 1'b0, 1'b1, 1'b0);
        add("walk_p3",          1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd0, 8'd3, 1'b1, 1'b1, 1'b0);
        add("pause_enter",      1'b1, 3'd0, 2'b00, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3'd0, 8'd3, 1'b0, 1'b0, 1'b0);
        add("pause_ign_nover",  1'b1, 3'd0, 2'b00, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1, 3'd0, 8'd3, 1'b0, 1'b0, 1'b0);
        add("pause_hold",       1'b1, 3'd0, 2'b00, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2, 3'd0, 8'd3, 1'b0, 1'b0, 1'b0);
        add("unpause_gap",      1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd0, 8'd3, 1'b0, 1'b1, 1'b0);
        add("unpause_gap_rest", 1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'd0, 8'd3, 1'b0, 1'b1, 1'b0);
        add("replay_note3",     1'b1, 3'd0, 2'b00, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd0, 8'd3, 1'b1, 1'b1, 1'b0);
        add("once_done",        1'b1, 3'd0, 2'b10, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        add("stop_ign_nover",   1'b1, 3'd0, 2'b10, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        add("stopped_hold",     1'b1, 3'd0, 2'b10, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        add("stopped_next",     1'b1, 3'd0, 2'b10, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1, 3'd1, 8'd0, 1'b0, 1'b1, 1'b0);
        add("stopped_next_gap", 1'b1, 3'd0, 2'b10, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'd1, 8'd0, 1'b0, 1'b1, 1'b0);
        add("after_next_play",  1'b1, 3'd0, 2'b10, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd1, 8'd0, 1'b1, 1'b1, 1'b0);
        add("prev_to_0",        1'b1, 3'd0, 2'b00, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1, 3'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        add("prev_wrap_7",      1'b1, 3'd0, 2'b00, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1, 3'd7, 8'd0, 1'b0, 1'b1, 1'b0);
        add("next_beats_prev",  1'b1, 3'd0, 2'b00, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1, 3'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        add("next_into_pause",  1'b1, 3'd0, 2'b00, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1, 3'd1, 8'd0, 1'b0, 1'b0, 1'b0);
        add("en_low_ign_next",  1'b0, 3'd3, 2'b00, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2, 3'd3, 8'd0, 1'b0, 1'b0, 1'b0);
        add("idle_ign_next",    1'b1, 3'd3, 2'b00, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1, 3'd3, 8'd0, 1'b1, 1'b1, 1'b0);
        add("repeat_one_done",  1'b1, 3'd3, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3'd3, 8'd0, 1'b0, 1'b1, 1'b1);
        add("repeat_one_gap",   1'b1, 3'd3, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'd3, 8'd0, 1'b0, 1'b1, 1'b0);
        add("repeat_one_play",  1'b1, 3'd3, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd3, 8'd0, 1'b1, 1'b1, 1'b0);
        add("repeat_one_again", 1'b1, 3'd3, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3'd3, 8'd0, 1'b0, 1'b1, 1'b1);
        add("pause_in_gap",     1'b1, 3'd3, 2'b01, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3'd3, 8'd0, 1'b0, 1'b0, 1'b0);
        add("resume_gap",       1'b1, 3'd3, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd3, 8'd0, 1'b0, 1'b1, 1'b0);
        add("resume_gap_rest",  1'b1, 3'd3, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'd3, 8'd0, 1'b0, 1'b1, 1'b0);
        add("resume_play",      1'b1, 3'd3, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3'd3, 8'd0, 1'b1, 1'b1, 1'b0);

        // Reset, then reset asserted mid-PLAY and released with en low.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_state", 32'(outs_a()), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("play_after_rst", 32'({ifa.sound_en, ifa.playing}), 32'd3);
        rst = 1'b1;
        #1;
        check("rst_mid_play", 32'(outs_a()), 32'd0);
        ifa.en = 1'b0;
        ifa.song_sel = 3'd5;
        @(posedge clk); #1;
        check("sel_held_in_rst", 32'(outs_a()), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("sel_after_rst", 32'(ifa.song_idx), 32'd5);

        // Table-driven vectors with a scoreboard of expected outputs.
        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < int'(vecs[i].reps); r++) begin
                ifa.en = vecs[i].en; ifa.song_sel = vecs[i].sel; ifa.mode = vecs[i].mode;
                ifa.rom_track = vecs[i].rom; ifa.pause = vecs[i].pause;
                ifa.next_btn = vecs[i].nxt; ifa.prev_btn = vecs[i].prv;
                ifa.note_over = vecs[i].nover;
                sb_q.push_back({vecs[i].e_song, vecs[i].e_note, vecs[i].e_snd,
                                vecs[i].e_play, vecs[i].e_done});
                @(posedge clk); #1;
                exp_o = sb_q.pop_front();
                check(names[i], 32'(outs_a()), 32'(exp_o));
            end
        end
        ifa.next_btn = 1'b0; ifa.prev_btn = 1'b0; ifa.note_over = 1'b0;

        // Shuffle: 50 song ends on the 5-song instance.
        ifb.en = 1'b1;
        for (int k = 0; k < 50; k++) begin
            w = 0;
            while (ifb.sound_en !== 1'b1 && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            check("shuf_reach_play", 32'(ifb.sound_en), 32'd1);
            prev_song = ifb.song_idx;
            ifb.note_over = 1'b1;
            @(posedge clk); #1;
            ifb.note_over = 1'b0;
            check("shuf_done_pulse", 32'(ifb.song_done), 32'd1);
            check("shuf_in_range", 32'(ifb.song_idx < 3'd5), 32'd1);
            check("shuf_no_repeat", 32'(ifb.song_idx != prev_song), 32'd1);
        end
        @(posedge clk); #1;
        check("shuf_done_single", 32'(ifb.song_done), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
